capture_seq_ctrl: RTL and testbench

//  Sequences one ADC capture/readout cycle in the packet-control clock domain, between pktctrl_top's capture memory and the pad interface.
//  Two phases:
//  - Capture: fills the capture memory with ADC words, one write per cycle.
//  - Readout: replays the memory as packets of ADC_DATA/ADC_DATA_VALID, with programmable idle gaps between packets.

---
 rtl/capture_seq_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_capture_seq_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_seq_ctrl.sv
// Capture/readout sequencer: fills the capture memory one word per cycle, then
// replays it as fixed-length packets separated by programmable idle gaps.
module capture_seq_ctrl #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 18,
    parameter int IDLE_W = 16
) (
    input  logic              pktctrl_clk,
    input  logic              pktctrl_rstn,
    input  logic              rf_capture_mode,
    input  logic              rf_capture_start,
    input  logic              rf_capture_again,
    input  logic [1:0]        rf_pkt_data_length,
    input  logic [IDLE_W-1:0] rf_pkt_idle_length,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] ADC_DATA,
    output logic              ADC_DATA_VALID,
    output logic              capture_busy,
    output logic              capture_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    state_t              state_q;
    logic                start_q;
    logic                again_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [10:0]         pkt_cnt_q;
    logic [10:0]         pkt_last_q;
    logic [IDLE_W-1:0]   idle_q;
    logic [IDLE_W-1:0]   gap_cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                rd_vld_q;
    logic [DATA_W-1:0]   adc_data_q;
    logic                adc_vld_q;

    logic start_rise;
    logic again_rise;

    assign start_rise = rf_capture_start & ~start_q;
    assign again_rise = rf_capture_again & ~again_q;

    // Index of the last word in a packet for each length code.
    function automatic logic [10:0] pkt_last_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return 11'd255;
            2'b01:   return 11'd511;
            2'b10:   return 11'd1023;
            default: return 11'd2047;
        endcase
    endfunction

    always_ff @(posedge pktctrl_clk or negedge pktctrl_rstn) begin
        if (!pktctrl_rstn) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            again_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            pkt_cnt_q  <= '0;
            pkt_last_q <= '0;
            idle_q     <= '0;
            gap_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_vld_q   <= 1'b0;
            adc_data_q <= '0;
            adc_vld_q  <= 1'b0;
        end else begin
            start_q <= rf_capture_start;
            again_q <= rf_capture_again;

            case (state_q)
                ST_IDLE: begin
                    if (start_rise) begin
                        state_q   <= ST_WRITE;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    if (!rf_capture_start) begin
                        state_q <= ST_IDLE;
                        wr_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (wr_addr_q == ADDR_LAST) begin
                        // Packet shape is frozen here for the whole readout.
                        state_q    <= ST_READ;
                        wr_en_q    <= 1'b0;
                        rd_en_q    <= 1'b1;
                        rd_addr_q  <= '0;
                        pkt_cnt_q  <= '0;
                        pkt_last_q <= pkt_last_of(rf_pkt_data_length);
                        idle_q     <= rf_pkt_idle_length;
                    end else begin
                        wr_addr_q <= wr_addr_q + ADDR_W'(1);
                    end
                end

                ST_READ: begin
                    if (!rf_capture_start) begin
                        state_q <= ST_IDLE;
                        rd_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (rd_addr_q == ADDR_LAST) begin
                        state_q <= ST_DONE;
                        rd_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                        if (pkt_cnt_q == pkt_last_q) begin
                            pkt_cnt_q <= '0;
                            if (idle_q != '0) begin
                                state_q   <= ST_GAP;
                                rd_en_q   <= 1'b0;
                                gap_cnt_q <= idle_q - IDLE_W'(1);
                            end
                        end else begin
                            pkt_cnt_q <= pkt_cnt_q + 11'd1;
                        end
                    end
                end

                ST_GAP: begin
                    if (!rf_capture_start) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (gap_cnt_q == '0) begin
                        state_q <= ST_READ;
                        rd_en_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - IDLE_W'(1);
                    end
                end

                ST_DONE: begin
                    // A new capture outranks a replay when both are requested.
                    if (rf_capture_mode || start_rise) begin
                        state_q   <= ST_WRITE;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end else if (again_rise) begin
                        state_q    <= ST_READ;
                        rd_en_q    <= 1'b1;
                        rd_addr_q  <= '0;
                        pkt_cnt_q  <= '0;
                        pkt_last_q <= pkt_last_of(rf_pkt_data_length);
                        idle_q     <= rf_pkt_idle_length;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    wr_en_q <= 1'b0;
                    rd_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase

            // Read data arrives one cycle after the strobe; words in flight drain even after an abort.
            rd_vld_q   <= rd_en_q;
            adc_vld_q  <= rd_vld_q;
            adc_data_q <= rd_vld_q ? mem_rd_data : '0;
        end
    end

    assign mem_wr_en      = wr_en_q;
    assign mem_wr_addr    = wr_addr_q;
    assign mem_rd_en      = rd_en_q;
    assign mem_rd_addr    = rd_addr_q;
    assign ADC_DATA       = adc_data_q;
    assign ADC_DATA_VALID = adc_vld_q;
    assign capture_busy   = busy_q;
    assign capture_done   = done_q;

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Scoreboard bench for capture_seq_ctrl: a behavioural capture memory feeds the DUT,
// expected packet streams are queued per readout and checked by a negedge monitor.
module tb_capture_seq_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 18;
    localparam int IW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          mode = 1'b0;
    logic          start = 1'b0;
    logic          again = 1'b0;
    logic [1:0]    len_sel = 2'b00;
    logic [IW-1:0] idle_len = '0;

    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic          capture_busy;
    logic          capture_done;

    capture_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW), .IDLE_W(IW)) dut (
        .pktctrl_clk       (clk),
        .pktctrl_rstn      (rstn),
        .rf_capture_mode   (mode),
        .rf_capture_start  (start),
        .rf_capture_again  (again),
        .rf_pkt_data_length(len_sel),
        .rf_pkt_idle_length(idle_len),
        .mem_wr_en         (mem_wr_en),
        .mem_wr_addr       (mem_wr_addr),
        .mem_rd_en         (mem_rd_en),
        .mem_rd_addr       (mem_rd_addr),
        .mem_rd_data       (mem_rd_data),
        .ADC_DATA          (adc_data),
        .ADC_DATA_VALID    (adc_valid),
        .capture_busy      (capture_busy),
        .capture_done      (capture_done)
    );

    always #5 clk = ~clk;

    // Capture memory with one-cycle registered read; write data comes from the bench's ADC source.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] adc_word = '0;
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= adc_word;
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    typedef struct {
        logic [DW-1:0] data;
        int            gap;   // idle cycles required before this word, -1 = don't care
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] cap_list [DEPTH];
    string         name_q[$];
    longint        act_q[$];
    longint        exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cap_cnt = 0;
    int wr_total = 0;
    bit sb_en = 1'b0;
    bit chk_done_len = 1'b0;

    // Expected readout: every captured word in address order, a gap of idle cycles before each new packet.
    task automatic push_readout();
        int len;
        len = 256 << len_sel;
        for (int k = 0; k < DEPTH; k++) begin
            exp_t e;
            e.data = cap_list[k];
            e.gap  = (k == 0) ? -1 : (((k % len) == 0) ? int'(idle_len) : 0);
            sb_q.push_back(e);
        end
    endtask

    task automatic expect_eq(input string nm, input longint act, input longint exv);
        name_q.push_back(nm);
        act_q.push_back(act);
        exp_q.push_back(exv);
    endtask

    // ---------------- monitor ----------------
    int wr_idx = 0;
    bit wr_en_prev = 1'b0;
    int idle_run = 0;
    bit done_prev = 1'b0;
    int done_run = 0;
    bit done_chk_cur = 1'b0;

    task automatic cmp(input string nm, input longint act, input longint exv);
        n_cmp++;
        if (act != exv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exv, $time);
        end
    endtask

    always @(negedge clk) begin
        while (act_q.size() > 0)
            cmp(name_q.pop_front(), act_q.pop_front(), exp_q.pop_front());

        cmp("wr_rd_exclusive", longint'(mem_wr_en & mem_rd_en), 0);

        adc_word = DW'($urandom);
        if (mem_wr_en) begin
            if (!wr_en_prev) wr_idx = 0;
            cmp("wr_addr", longint'(mem_wr_addr), longint'(wr_idx));
            if (wr_idx < DEPTH) cap_list[wr_idx] = adc_word;
            wr_idx++;
            wr_total++;
            if (wr_idx == DEPTH) begin
                cap_cnt++;
                if (sb_en) push_readout();
            end
        end
        wr_en_prev = mem_wr_en;

        if (adc_valid) begin
            if (sb_en) begin
                if (sb_q.size() == 0) begin
                    cmp("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    cmp("adc_data", longint'(adc_data), longint'(e.data));
                    if (e.gap >= 0) cmp("idle_gap", longint'(idle_run), longint'(e.gap));
                end
            end
            idle_run = 0;
        end else begin
            cmp("data_zero_when_invalid", longint'(adc_data), 0);
            idle_run++;
        end

        if (capture_done && !done_prev) begin
            done_run = 1;
            done_chk_cur = chk_done_len;
        end else if (capture_done) begin
            done_run++;
        end else if (done_prev && done_chk_cur && chk_done_len) begin
            cmp("done_len_mode1", longint'(done_run), 1);
        end
        done_prev = capture_done;
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!capture_done && n < budget);
        expect_eq("done_reached", longint'(capture_done), 1);
    endtask

    task automatic post_done(input int cap_before, input int cap_inc);
        expect_eq("done_flag", longint'(capture_done), 1);
        expect_eq("busy_in_done", longint'(capture_busy), 0);
        repeat (4) @(negedge clk);
        expect_eq("sb_drained", longint'(sb_q.size()), 0);
        expect_eq("capture_count", longint'(cap_cnt - cap_before), longint'(cap_inc));
    endtask

    task automatic restart_from_done();
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
    endtask

    task automatic expect_all_zero(input string tag);
        expect_eq({tag, "_wr_en"}, longint'(mem_wr_en), 0);
        expect_eq({tag, "_wr_addr"}, longint'(mem_wr_addr), 0);
        expect_eq({tag, "_rd_en"}, longint'(mem_rd_en), 0);
        expect_eq({tag, "_rd_addr"}, longint'(mem_rd_addr), 0);
        expect_eq({tag, "_adc_data"}, longint'(adc_data), 0);
        expect_eq({tag, "_valid"}, longint'(adc_valid), 0);
        expect_eq({tag, "_busy"}, longint'(capture_busy), 0);
        expect_eq({tag, "_done"}, longint'(capture_done), 0);
    endtask

    initial begin
        int cb;
        int wb;
        int n;
        int loops;
        bit dprev;
        bit found;

        repeat (3) @(negedge clk);
        expect_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);
        sb_en = 1'b1;

        // Basic capture: 256-word packets back to back.
        len_sel = 2'b00; idle_len = '0; cb = cap_cnt;
        $display("run basic len=256 idle=0");
        start = 1'b1;
        wait_done(4000);
        post_done(cb, 1);

        // Four packets with 5 idle cycles between them.
        len_sel = 2'b00; idle_len = IW'(5); cb = cap_cnt;
        $display("run gapped len=256 idle=5");
        restart_from_done();
        wait_done(4000);
        post_done(cb, 1);

        for (int r = 0; r < 3; r++) begin
            len_sel  = 2'($urandom_range(0, 3));
            idle_len = IW'($urandom_range(0, 12));
            cb = cap_cnt;
            $display("run random len=%0d idle=%0d", 256 << len_sel, idle_len);
            restart_from_done();
            wait_done(6000);
            post_done(cb, 1);
        end

        // Replay without recapture; packet settings changed mid-readout must be ignored.
        len_sel  = 2'($urandom_range(0, 3));
        idle_len = IW'($urandom_range(1, 9));
        $display("run replay len=%0d idle=%0d", 256 << len_sel, idle_len);
        push_readout();
        cb = cap_cnt; wb = wr_total;
        again = 1'b1;
        @(negedge clk);
        again = 1'b0;
        n = 0;
        while (!mem_rd_en && n < 10) begin @(negedge clk); n++; end
        expect_eq("replay_started", longint'(mem_rd_en), 1);
        len_sel  = len_sel + 2'd1;
        idle_len = idle_len + IW'(3);
        wait_done(6000);
        post_done(cb, 0);
        expect_eq("replay_no_writes", longint'(wr_total - wb), 0);

        // Start and again rising together: capture wins.
        len_sel  = 2'($urandom_range(0, 3));
        idle_len = IW'($urandom_range(0, 12));
        $display("run start+again len=%0d idle=%0d", 256 << len_sel, idle_len);
        cb = cap_cnt;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; again = 1'b1;
        @(negedge clk);
        again = 1'b0;
        expect_eq("start_wins_wr_en", longint'(mem_wr_en), 1);
        expect_eq("start_wins_rd_en", longint'(mem_rd_en), 0);
        wait_done(6000);
        post_done(cb, 1);

        // Continuous mode: three full loops, each DONE lasting one cycle.
        $display("run continuous x3 len=%0d idle=%0d", 256 << len_sel, idle_len);
        cb = cap_cnt;
        chk_done_len = 1'b1;
        mode = 1'b1;
        loops = 0; dprev = 1'b1; n = 0;
        while (loops < 3 && n < 9000) begin
            @(negedge clk);
            n++;
            if (capture_done && !dprev) loops++;
            dprev = capture_done;
        end
        mode = 1'b0;
        chk_done_len = 1'b0;
        expect_eq("mode1_loops", longint'(loops), 3);
        post_done(cb, 3);

        // Abort during capture at address 300.
        sb_en = 1'b0;
        sb_q.delete();
        $display("run abort-write at addr 300");
        restart_from_done();
        found = 1'b0; n = 0;
        while (!found && n < 2000) begin
            @(negedge clk);
            n++;
            found = mem_wr_en && (mem_wr_addr == AW'(300));
        end
        expect_eq("reached_wr300", longint'(found), 1);
        start = 1'b0;
        @(negedge clk);
        expect_eq("abort_wr_wr_en", longint'(mem_wr_en), 0);
        expect_eq("abort_wr_rd_en", longint'(mem_rd_en), 0);
        expect_eq("abort_wr_busy", longint'(capture_busy), 0);
        expect_eq("abort_wr_done", longint'(capture_done), 0);
        repeat (2) @(negedge clk);
        expect_eq("abort_wr_valid", longint'(adc_valid), 0);

        // Abort during readout at word 100.
        $display("run abort-read at word 100");
        start = 1'b1;
        found = 1'b0; n = 0;
        while (!found && n < 3000) begin
            @(negedge clk);
            n++;
            found = mem_rd_en && (mem_rd_addr == AW'(100));
        end
        expect_eq("reached_rd100", longint'(found), 1);
        start = 1'b0;
        @(negedge clk);
        expect_eq("abort_rd_rd_en", longint'(mem_rd_en), 0);
        expect_eq("abort_rd_wr_en", longint'(mem_wr_en), 0);
        expect_eq("abort_rd_busy", longint'(capture_busy), 0);
        repeat (2) @(negedge clk);
        expect_eq("abort_rd_valid", longint'(adc_valid), 0);

        // Asynchronous reset in the middle of an idle gap.
        $display("run reset-in-gap len=256 idle=7");
        len_sel = 2'b00; idle_len = IW'(7);
        start = 1'b1;
        found = 1'b0; n = 0;
        while (!found && n < 3000) begin
            @(negedge clk);
            n++;
            found = capture_busy && !mem_wr_en && !mem_rd_en;
        end
        expect_eq("reached_gap", longint'(found), 1);
        start = 1'b0;
        rstn = 1'b0;
        #1;
        expect_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        expect_eq("post_rst_busy", longint'(capture_busy), 0);
        expect_eq("post_rst_wr_en", longint'(mem_wr_en), 0);
        start = 1'b1;
        @(negedge clk);
        expect_eq("post_rst_start_wr_en", longint'(mem_wr_en), 1);
        expect_eq("post_rst_start_addr", longint'(mem_wr_addr), 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
